// File: rtl/vec_issue_if.sv
// Handshake and datapath bundle between the scalar processor side and vec_issue_ctrl.
interface vec_issue_if #(
  parameter int unsigned XLEN = 32
);
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] instruction;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            is_vec;
  logic            csr_done;
  logic            is_loaded;
  logic [XLEN-1:0] inst_held;
  logic [XLEN-1:0] rs1_held;
  logic [XLEN-1:0] rs2_held;
  logic            dp_start;
  logic            vec_pro_ack;
  logic            illegal;
  logic            timeout_err;
  logic            busy;

  modport master (
    output inst_valid, instruction, rs1_data, rs2_data, is_vec, csr_done, is_loaded,
    input  inst_ready, inst_held, rs1_held, rs2_held, dp_start, vec_pro_ack, illegal,
           timeout_err, busy
  );

  modport slave (
    input  inst_valid, instruction, rs1_data, rs2_data, is_vec, csr_done, is_loaded,
    output inst_ready, inst_held, rs1_held, rs2_held, dp_start, vec_pro_ack, illegal,
           timeout_err, busy
  );
endinterface

// File: rtl/vec_issue_ctrl.sv
// Vector instruction issue controller: IDLE -> DECODE -> EXEC -> RESP, one op in flight.
// Optional EXEC watchdog enabled by defining VEC_ISSUE_TIMEOUT_EN.
module vec_issue_ctrl #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input logic        clk,
  input logic        reset,
  vec_issue_if.slave bus
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StDecode = 2'd1;
  localparam logic [1:0] StExec   = 2'd2;
  localparam logic [1:0] StResp   = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] inst_q, rs1_q, rs2_q;
  logic            illegal_q, illegal_d;
  logic            dp_start_q, dp_start_d;
  logic            handshake;
  logic            done;
  logic            timeout_hit;

  assign handshake = bus.inst_valid && (state_q == StIdle);
  assign done      = bus.csr_done || bus.is_loaded;

  always_comb begin
    state_d    = state_q;
    illegal_d  = 1'b0;
    dp_start_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.inst_valid) state_d = StDecode;
      end
      StDecode: begin
        if (bus.is_vec) begin
          state_d    = StExec;
          dp_start_d = 1'b1;
        end else begin
          state_d   = StIdle;
          illegal_d = 1'b1;
        end
      end
      StExec: begin
        // A completion in the final watchdog cycle takes priority over the abort.
        if (done) begin
          state_d = StResp;
        end else if (timeout_hit) begin
          state_d = StIdle;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      inst_q     <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      illegal_q  <= 1'b0;
      dp_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      illegal_q  <= illegal_d;
      dp_start_q <= dp_start_d;
      if (handshake) begin
        inst_q <= bus.instruction;
        rs1_q  <= bus.rs1_data;
        rs2_q  <= bus.rs2_data;
      end
    end
  end

`ifdef VEC_ISSUE_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT);

  logic [CntW-1:0] cnt_q;
  logic            timeout_q;

  // cnt_q holds the number of EXEC cycles already spent before the current one.
  assign timeout_hit = (cnt_q == CntW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= (state_q == StExec) && !done && timeout_hit;
      if (state_q == StDecode) begin
        cnt_q <= '0;
      end else if (state_q == StExec) begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

  assign bus.timeout_err = timeout_q;
`else
  assign timeout_hit     = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.inst_ready  = (state_q == StIdle);
  assign bus.busy        = (state_q != StIdle);
  assign bus.vec_pro_ack = (state_q == StResp);
  assign bus.dp_start    = dp_start_q;
  assign bus.illegal     = illegal_q;
  assign bus.inst_held   = inst_q;
  assign bus.rs1_held    = rs1_q;
  assign bus.rs2_held    = rs2_q;

endmodule

// File: doc/vec_issue_ctrl.md
VEC_ISSUE_CTRL -- requirements
Module: vec_issue_ctrl

Interface
REQ-001 Parameter XLEN, 32, width of instruction and scalar operands.
REQ-002 Parameter TIMEOUT, 255, maximum EXEC cycles before abort (>=2).
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 inst_valid  in  1  scalar processor offers an instruction.
REQ-006 inst_ready  out  1  controller can accept an instruction.
REQ-007 instruction  in  XLEN  vector instruction from the scalar processor.
REQ-008 rs1_data, rs2_data  in  XLEN each  scalar operands from the scalar processor.
REQ-009 is_vec  in  1  decoder legality flag for inst_held (combinational).
REQ-010 csr_done  in  1  CSR regfile completion.
REQ-011 is_loaded  in  1  LSU completion.
REQ-012 inst_held, rs1_held, rs2_held  out  XLEN each  latched operands driven to the datapath.
REQ-013 dp_start  out  1  one-cycle pulse that starts execution.
REQ-014 vec_pro_ack  out  1  one-cycle completion pulse to the scalar processor.
REQ-015 illegal  out  1  one-cycle pulse: instruction rejected as non-vector.
REQ-016 timeout_err  out  1  one-cycle pulse: execution aborted.
REQ-017 busy  out  1  high whenever state != IDLE.

Function
REQ-018 FSM states SHALL be IDLE, DECODE, EXEC and RESP.
REQ-019 inst_ready SHALL be 1 only in IDLE; a handshake is inst_valid && inst_ready.
REQ-020 On handshake in cycle A, instruction/rs1/rs2 SHALL be latched into the held registers; state is DECODE in A+1.
- Held registers SHALL change only on handshake or reset.
REQ-021 In DECODE:
- is_vec=1: next state EXEC.
- is_vec=0: next state IDLE, and illegal=1 for exactly the following cycle.
REQ-022 dp_start SHALL be 1 in the first EXEC cycle only.
REQ-023 In any EXEC cycle (including the first) with csr_done||is_loaded=1, next state SHALL be RESP.
REQ-024 In RESP, vec_pro_ack SHALL be 1 for that single cycle; next state is IDLE.
- Handshake-to-ack minimum latency: A+3.
REQ-025 csr_done/is_loaded SHALL be ignored in IDLE, DECODE and RESP.
REQ-026 Simultaneous csr_done and is_loaded SHALL produce a single vec_pro_ack.
REQ-027 At most one instruction SHALL be outstanding; no new handshake until back in IDLE.
REQ-028 illegal, vec_pro_ack, timeout_err and dp_start SHALL be mutually exclusive in any cycle.

Reset
REQ-029 While reset=1 at a clock edge, the block SHALL return to IDLE from any state (including mid-EXEC).
- Held registers, the counter and all pulses SHALL clear to 0.
- inst_ready=1 and busy=0 in the first cycle after reset deasserts.
- A completion pending at reset SHALL NOT generate an ack.

Configuration
REQ-030 With VEC_ISSUE_TIMEOUT_EN defined, an EXEC cycle counter SHALL be cleared on EXEC entry and increment each EXEC cycle.
- If no completion arrives by the TIMEOUT-th EXEC cycle, next state SHALL be IDLE and timeout_err=1 for the following cycle.
- A completion in that same final cycle SHALL win: RESP, no timeout_err.
REQ-031 Without VEC_ISSUE_TIMEOUT_EN, the counter SHALL be absent, EXEC SHALL wait indefinitely and timeout_err SHALL be tied to 0.

Verification
REQ-032 Legal op: handshake with instruction=0x0D0572D7, is_vec=1, csr_done two cycles after dp_start -> dp_start at A+2, vec_pro_ack at A+5, inst_ready=1 at A+6.
REQ-033 Illegal op: handshake with is_vec=0 in DECODE -> illegal at A+2, no dp_start, no vec_pro_ack, inst_ready=1 at A+2.
REQ-034 Back-to-back: inst_valid held high across two instructions (0x11, 0x22) -> second handshake only after first ack; inst_held=0x22 only after the second handshake.
REQ-035 Timeout (macro on, TIMEOUT=4): no completion -> timeout_err one cycle after the 4th EXEC cycle; repeat with is_loaded in the 4th EXEC cycle -> vec_pro_ack, no timeout_err.
REQ-036 Reset mid-EXEC, is_loaded asserted in the next cycle -> no vec_pro_ack, all outputs 0 except inst_ready=1, held registers=0.
REQ-037 Stray completion: csr_done=1 in IDLE and in DECODE -> no vec_pro_ack and no state change beyond the normal flow.
